crack_sched: RTL and testbench
==============================

# crack_sched

Parametrised key-space scheduler for the ARC4 brute-force cracker. Accepts a key range and hands keys to `NUM_CORES` parallel crack cores using the `en`/`rdy` start handshake. It tracks which cores are busy, collects their found/not-found results and stops the search on the first hit. It sits between the top-level `task4`-style wrapper (HEX/LEDR display) and an array of crack cores, replacing the single-core sequential key loop.

## Interface
- `NUM_CORES`, default 2, number of crack cores (1–16).
- `KEY_W`, default 24, key width in bits.

- `clk`  in  1  system clock (CLOCK_50).
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  start request; accepted only in a cycle where `rdy`=1.
- `rdy`  out  1  scheduler idle or finished; a new search may start.
- `key_lo`  in  KEY_W  first key, inclusive; sampled on the accepted `en`.
- `key_hi`  in  KEY_W  last key, inclusive; sampled on the accepted `en`.
- `core_en`  out  NUM_CORES  one-cycle start pulse per core.
- `core_key`  out  NUM_CORES*KEY_W  key for core i, in bits [i*KEY_W +: KEY_W]; stable while core i is busy.
- `core_rdy`  in  NUM_CORES  core i can accept a start.
- `core_done`  in  NUM_CORES  one-cycle completion pulse from core i.
- `core_found`  in  NUM_CORES  qualified by `core_done`; the key decrypted to printable ASCII.
- `key`  out  KEY_W  key that was found; valid when `key_valid`=1.
- `key_valid`  out  1  a key was found; sticky until the next accepted `en`.
- `done`  out  1  search complete; sticky until the next accepted `en`.

## Operation
- Reset values: state IDLE, `rdy`=1, all other outputs 0, all busy bits 0.
- States:
  - IDLE → DISPATCH on `en`.
  - DISPATCH → DRAIN when a hit is recorded or the range is exhausted.
  - DRAIN → DONE when no core is busy.
  - DONE → DISPATCH on `en`.
- Empty range (`key_lo` > `key_hi`): go directly to DRAIN; no `core_en`; result `done`=1, `key_valid`=0.
- Next-key counter is KEY_W+1 bits wide, so `key_hi`=all-ones terminates without wrapping to 0.
- DISPATCH issues at most one key per cycle.
  - Target is the lowest-index core with `core_rdy`=1 and busy=0.
  - On issue: pulse `core_en[i]`, load `core_key[i]`, set busy[i], increment the next-key counter.
  - Range is exhausted when the counter exceeds `key_hi`.
- `core_done[i]` clears busy[i]. A `core_done` from a non-busy core is ignored.
- Hit: `core_done[i]` && `core_found[i]` while in DISPATCH or DRAIN, with no earlier hit recorded.
  - Capture `core_key[i]` into `key`; set `key_valid`.
  - Several hits in the same cycle: the lowest key value wins.
  - Hits after the first are ignored.
- A hit in the same cycle as a dispatch opportunity blocks that dispatch.
- DRAIN waits for every in-flight core to finish so no core is abandoned mid-RAM-access. Results arriving during DRAIN only clear busy bits, apart from the hit rule above.
- `en` while `rdy`=0 is ignored.
- `rst` mid-search returns to IDLE immediately. In-flight cores are not tracked afterwards; their later `core_done` pulses are ignored.

## Timing
- Accepted `en` at edge N → earliest `core_en` at edge N+1. All outputs are registered.
- Back-to-back dispatch: one core per cycle while idle cores exist.
- Last busy bit clears at edge M → `done`=1 and `rdy`=1 at edge M+1. `key`/`key_valid` are valid no later than `done`.
- Restart from DONE clears `done`, `key_valid` and `key` at the accepting edge.

## Configuration
- `CRACK_SCHED_PROGRESS_EN` defined: adds output `tried` (KEY_W+1 bits).
  - Counts completed `core_done` pulses from busy cores.
  - Reset to 0; cleared on accepted `en`; frozen in DONE.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- `crack_pkg`: state enum (IDLE, DISPATCH, DRAIN, DONE) and constant `CRACK_KEY_W_DEFAULT`=24.
- Sub-module `crack_pick_lowest`: priority encoder giving the lowest index of (`core_rdy` & ~busy), plus a valid flag. Reused for tie-breaking among hit candidates.

## Test plan
- NUM_CORES=2, range 0..5, cores return not-found after 3 cycles → keys 0–5 each issued exactly once; then `done`=1, `key_valid`=0, `rdy`=1.
- Same setup, core returns found on key 3 → `key`=0x000003, `key_valid`=1; no key > 4 issued after the hit cycle; `done` only after in-flight keys finish.
- NUM_CORES=4, keys 0x12 and 0x10 report found in the same cycle → `key`=0x000010.
- Range 0xFFFFFE..0xFFFFFF → exactly two `core_en` pulses, no key 0x000000 issued, `done`=1.
- Range 0x10..0x05 → no `core_en`; `done`=1 within 3 cycles of `en`; `key_valid`=0.
- `rst` pulsed mid-DISPATCH, then a stray `core_done`/`core_found` → outputs at reset values, `key_valid` stays 0; a following `en` with range 0..1 completes normally.

Source files
------------

// File: rtl/crack_sched_pkg.sv
// crack_pkg: scheduler state encoding and default key width shared by crack_sched files
package crack_pkg;
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
  localparam int CRACK_KEY_W_DEFAULT = 24;
endpackage

// File: rtl/crack_pick_lowest.sv
// crack_pick_lowest: priority encoder returning the lowest set index of req plus a valid flag
module crack_pick_lowest #(
  parameter int N = 2,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
  end
  assign valid = |req;
endmodule

// File: rtl/crack_sched.sv
// crack_sched: dispatches a key range over NUM_CORES crack cores, stops on first hit; CRACK_SCHED_PROGRESS_EN adds output tried
module crack_sched
  import crack_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int KEY_W = CRACK_KEY_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     rdy,
  input  logic [KEY_W-1:0]         key_lo,
  input  logic [KEY_W-1:0]         key_hi,
  output logic [NUM_CORES-1:0]     core_en,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  input  logic [NUM_CORES-1:0]     core_rdy,
  input  logic [NUM_CORES-1:0]     core_done,
  input  logic [NUM_CORES-1:0]     core_found,
  output logic [KEY_W-1:0]         key,
  output logic                     key_valid,
  output logic                     done
`ifdef CRACK_SCHED_PROGRESS_EN
  ,
  output logic [KEY_W:0]           tried
`endif
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  state_t state_q, state_d;
  logic [NUM_CORES-1:0] busy_q, busy_d, core_en_q, core_en_d, hit, win;
  logic [KEY_W:0] next_q, next_d;
  logic [KEY_W-1:0] hi_q, hi_d, key_q, key_d;
  logic [KEY_W-1:0] ck_q [NUM_CORES];
  logic [KEY_W-1:0] ck_d [NUM_CORES];
  logic key_valid_q, key_valid_d, done_q, done_d, accept, active, issue;
  logic [IW-1:0] free_idx, win_idx;
  logic free_ok, win_ok;
  assign rdy = state_q == IDLE || state_q == DONE;
  assign accept = en && rdy;
  assign active = state_q == DISPATCH || state_q == DRAIN;
  assign hit = core_done & core_found & busy_q & {NUM_CORES{active && !key_valid_q}};
  always_comb begin
    win = hit;
    for (int i = 0; i < NUM_CORES; i++)
      for (int j = 0; j < NUM_CORES; j++)
        if (hit[j] && ck_q[j] < ck_q[i]) win[i] = 1'b0;
  end
  crack_pick_lowest #(.N(NUM_CORES)) u_free (.req(core_rdy & ~busy_q), .idx(free_idx), .valid(free_ok));
  crack_pick_lowest #(.N(NUM_CORES)) u_hit (.req(win), .idx(win_idx), .valid(win_ok));
  assign issue = state_q == DISPATCH && free_ok && !win_ok;
  always_comb begin
    state_d = state_q;
    busy_d = busy_q & ~core_done;
    core_en_d = '0;
    next_d = next_q;
    hi_d = hi_q;
    ck_d = ck_q;
    key_d = key_q;
    key_valid_d = key_valid_q;
    done_d = done_q;
    if (accept) begin
      next_d = {1'b0, key_lo};
      hi_d = key_hi;
      key_d = '0;
      key_valid_d = 1'b0;
      done_d = 1'b0;
      state_d = key_lo > key_hi ? DRAIN : DISPATCH;
    end
    if (win_ok) begin
      key_d = ck_q[win_idx];
      key_valid_d = 1'b1;
    end
    if (issue) begin
      core_en_d[free_idx] = 1'b1;
      ck_d[free_idx] = next_q[KEY_W-1:0];
      busy_d[free_idx] = 1'b1;
      next_d = next_q + 1'b1;
    end
    if (state_q == DISPATCH && (win_ok || next_d > {1'b0, hi_q})) state_d = DRAIN;
    if (state_q == DRAIN && busy_q == '0) begin
      state_d = DONE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= '0;
      core_en_q <= '0;
      next_q <= '0;
      hi_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) ck_q[i] <= '0;
      key_q <= '0;
      key_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      core_en_q <= core_en_d;
      next_q <= next_d;
      hi_q <= hi_d;
      ck_q <= ck_d;
      key_q <= key_d;
      key_valid_q <= key_valid_d;
      done_q <= done_d;
    end
  end
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
    assign core_key[g*KEY_W +: KEY_W] = ck_q[g];
  end
  assign core_en = core_en_q;
  assign key = key_q;
  assign key_valid = key_valid_q;
  assign done = done_q;
`ifdef CRACK_SCHED_PROGRESS_EN
  logic [KEY_W:0] tried_q, tried_d;
  always_comb begin
    tried_d = tried_q;
    for (int i = 0; i < NUM_CORES; i++) tried_d = tried_d + (KEY_W+1)'(active && core_done[i] && busy_q[i]);
    tried_d = accept ? '0 : tried_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tried_q <= '0;
    else tried_q <= tried_d;
  end
  assign tried = tried_q;
`endif
endmodule

// File: tb/tb_crack_sched.sv
// tb_crack_sched: directed self-checking bench for crack_sched with behavioural crack cores
module tb_crack_sched;
  localparam int N = 4;
  localparam int W = 24;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [W-1:0] key_lo = '0, key_hi = '0;
  logic rdy, key_valid, done;
  logic [N-1:0] core_en, core_rdy, core_done, core_found;
  logic [N*W-1:0] core_key;
  logic [W-1:0] key;
  int checks = 0, failures = 0;
  logic [N-1:0] mask = '0, act = '0, done_r = '0;
  int cnt [N];
  int lat [N];
  logic [W-1:0] ck [N];
  logic fen = 1'b0;
  logic [W-1:0] fk0 = '0, fk1 = '0;
  logic [W-1:0] issued [$];
  always #5 clk = ~clk;
  crack_sched #(.NUM_CORES(N), .KEY_W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key_lo(key_lo), .key_hi(key_hi),
    .core_en(core_en), .core_key(core_key), .core_rdy(core_rdy), .core_done(core_done),
    .core_found(core_found), .key(key), .key_valid(key_valid), .done(done)
  );
  always @(posedge clk)
    for (int i = 0; i < N; i++) begin
      done_r[i] <= 1'b0;
      if (core_en[i]) begin
        act[i] <= 1'b1;
        cnt[i] <= lat[i];
        ck[i] <= core_key[i*W +: W];
      end else if (act[i]) begin
        if (cnt[i] == 1) begin
          done_r[i] <= 1'b1;
          act[i] <= 1'b0;
        end
        cnt[i] <= cnt[i] - 1;
      end
    end
  for (genvar g = 0; g < N; g++) begin : g_core
    assign core_rdy[g] = mask[g] & ~act[g];
    assign core_found[g] = done_r[g] & fen & (ck[g] == fk0 || ck[g] == fk1);
  end
  assign core_done = done_r;
  always @(negedge clk)
    for (int i = 0; i < N; i++)
      if (core_en[i]) issued.push_back(core_key[i*W +: W]);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [W-1:0] lo, input logic [W-1:0] hi);
    @(negedge clk);
    issued.delete();
    key_lo = lo;
    key_hi = hi;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int c = 0;
    while (!done && c < 300) begin
      @(posedge clk);
      #1 c++;
    end
    chk({tag, "_done"}, 32'(done), 1);
  endtask
  initial begin
    int cyc;
    logic [W-1:0] mx;
    for (int i = 0; i < N; i++) begin
      lat[i] = 3;
      cnt[i] = 0;
      ck[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_kv", 32'(key_valid), 0);
    chk("rst_core_en", 32'(core_en), 0);
    chk("rst_key", 32'(key), 0);
    chk("rst_core_key_zero", 32'(core_key == '0), 1);
    mask = 4'b0011;
    start(24'h0, 24'h5);
    chk("t1_busy_rdy", 32'(rdy), 0);
    @(negedge clk);
    key_lo = 24'h40;
    key_hi = 24'h40;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    wait_done("t1");
    chk("t1_count", issued.size(), 6);
    for (int k = 0; k < 6; k++) chk("t1_key_order", 32'(issued[k]), k);
    chk("t1_kv", 32'(key_valid), 0);
    chk("t1_rdy", 32'(rdy), 1);
    fen = 1'b1;
    fk0 = 24'h3;
    fk1 = 24'h3;
    start(24'h0, 24'h5);
    wait_done("t2");
    chk("t2_key", 32'(key), 32'h3);
    chk("t2_kv", 32'(key_valid), 1);
    mx = '0;
    foreach (issued[k]) mx = issued[k] > mx ? issued[k] : mx;
    chk("t2_no_key_after_hit", 32'(mx <= 24'h4), 1);
    chk("t2_cores_idle", 32'(act), 0);
    mask = 4'b1111;
    lat[0] = 4;
    lat[1] = 3;
    lat[2] = 2;
    lat[3] = 3;
    fk0 = 24'h12;
    fk1 = 24'h10;
    start(24'h10, 24'h13);
    chk("t3_restart_done", 32'(done), 0);
    chk("t3_restart_kv", 32'(key_valid), 0);
    chk("t3_restart_key", 32'(key), 0);
    wait_done("t3");
    chk("t3_key_lowest", 32'(key), 32'h10);
    chk("t3_kv", 32'(key_valid), 1);
    chk("t3_count", issued.size(), 4);
    mask = 4'b0011;
    for (int i = 0; i < N; i++) lat[i] = 3;
    fen = 1'b0;
    start(24'hFFFFFE, 24'hFFFFFF);
    wait_done("t4");
    chk("t4_count", issued.size(), 2);
    chk("t4_key0", 32'(issued[0]), 32'hFFFFFE);
    chk("t4_key1", 32'(issued[1]), 32'hFFFFFF);
    chk("t4_kv", 32'(key_valid), 0);
    start(24'h10, 24'h05);
    cyc = 0;
    while (!done && cyc < 10) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("t5_done", 32'(done), 1);
    chk("t5_within_3", 32'(cyc <= 3), 1);
    chk("t5_no_core_en", issued.size(), 0);
    chk("t5_kv", 32'(key_valid), 0);
    fen = 1'b1;
    fk0 = 24'h0;
    fk1 = 24'h0;
    start(24'h0, 24'h5);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("t6_async_rdy", 32'(rdy), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_core_en", 32'(core_en), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_kv", 32'(key_valid), 0);
    cyc = 0;
    while (act != '0 && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    repeat (2) @(posedge clk);
    #1 chk("t6_stray_kv", 32'(key_valid), 0);
    chk("t6_stray_key", 32'(key), 0);
    chk("t6_stray_rdy", 32'(rdy), 1);
    chk("t6_stray_done", 32'(done), 0);
    fen = 1'b0;
    start(24'h0, 24'h1);
    wait_done("t6_rerun");
    chk("t6_rerun_count", issued.size(), 2);
    chk("t6_rerun_kv", 32'(key_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
